timer_unit: RTL and testbench
=============================

TIMER_UNIT -- requirements
Module: timer_unit

Interface
REQ-001 The block SHALL have parameter TIMESIZE, default 12, giving the width of the InitVal field and of the countdown register TVAL.
REQ-002 The block SHALL have parameter CSR_AW, default 14, giving the CSR address width.
REQ-003 aclk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 csr_we  in  1  CSR write strobe, one write per asserted cycle.
REQ-006 csr_waddr  in  CSR_AW  write address: TCFG=0x041, TVAL=0x042, TICLR=0x044.
REQ-007 csr_wdata  in  32  write data.
REQ-008 csr_raddr  in  CSR_AW  read address.
REQ-009 csr_rdata  out  32  combinational read data.
REQ-010 ti_irq  out  1  timer interrupt pending (ESTAT.IS[11]).
REQ-011 stable_cnt  out  64  free-running stable counter for rdcnt.

Function
REQ-012 TCFG SHALL hold TIMESIZE+2 bits: bit0 En, bit1 Periodic, bits[TIMESIZE+1:2] InitVal; write mask = low TIMESIZE+2 bits, upper bits read 0.
REQ-013 The timer FSM SHALL have states IDLE, RUN and DONE.
REQ-014 A TCFG write with En=1 SHALL load TVAL<=InitVal and enter RUN on the next edge, from any state.
REQ-015 A TCFG write with En=0 SHALL enter IDLE; TVAL SHALL hold its current value.
REQ-016 In RUN with TVAL!=0, TVAL SHALL decrement by 1 per cycle.
REQ-017 In RUN with TVAL==0 (expiry), ti_irq SHALL be set to 1 on the next edge.
REQ-018 On expiry with Periodic=1, TVAL SHALL reload InitVal and the FSM SHALL stay in RUN; the period is InitVal+1 cycles.
REQ-019 On expiry with Periodic=0, the FSM SHALL enter DONE with TVAL held at 0 and no further expiries.
REQ-020 InitVal=0 with Periodic=1 SHALL expire every cycle.
REQ-021 IDLE and DONE SHALL NOT change TVAL.
REQ-022 A TICLR write with wdata[0]=1 SHALL clear ti_irq; wdata[0]=0 SHALL have no effect.
REQ-023 If an expiry and a TICLR clear occur in the same cycle, the set SHALL win and ti_irq stays 1.
REQ-024 If a TCFG write and an expiry occur in the same cycle, the write SHALL determine next TVAL and FSM state, and ti_irq SHALL still be set.
REQ-025 Writes to TVAL SHALL be ignored.
REQ-026 Reads: TCFG -> zero-extended TCFG; TVAL -> zero-extended TVAL; TICLR -> 0; any other address -> 0.
REQ-027 Writes to addresses other than TCFG and TICLR SHALL have no effect.

Reset
REQ-028 On reset assertion, immediately and independent of aclk: TCFG=0, TVAL=0, FSM=IDLE, ti_irq=0, stable_cnt=0.
REQ-029 Reset asserted mid-count SHALL abort the count; after release the timer SHALL stay IDLE until a TCFG write with En=1.

Configuration
REQ-030 Macro TIMER_STABLE_CNT_EN defined: stable_cnt SHALL be a 64-bit counter incrementing every cycle after reset, wrapping from all-ones to 0.
REQ-031 Macro TIMER_STABLE_CNT_EN undefined: stable_cnt SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-032 Write TCFG InitVal=5, Periodic=0, En=1 -> TVAL reads 5,4,3,2,1,0 on successive cycles; ti_irq=1 one cycle after TVAL=0; TVAL stays 0 with no further expiry.
REQ-033 Write TCFG InitVal=3, Periodic=1, En=1 -> ti_irq rising every 4 cycles when cleared by TICLR=1 between expiries; an expiry coinciding with the TICLR write leaves ti_irq=1.
REQ-034 Mid-count (TVAL=7), write TCFG En=0 -> TVAL holds 7 and ti_irq stays 0; then write En=1 with InitVal=2 -> TVAL=2 next cycle, then counts down.
REQ-035 Write TVAL=0x123 and read address 0x050 -> TVAL unchanged, rdata=0; TCFG write 0xFFFFFFFF with TIMESIZE=12 -> TCFG reads 0x00003FFF.
REQ-036 Assert reset mid-count with ti_irq=1 -> all outputs 0 without a clock edge; with TIMER_STABLE_CNT_EN, stable_cnt=N exactly N cycles after release, and it wraps from 0xFFFFFFFFFFFFFFFF to 0 when preloaded in simulation.

Source files
------------

// File: rtl/timer_unit.sv
// timer_unit: CSR-mapped countdown timer with interrupt and optional stable counter.
// TCFG (0x041) holds En/Periodic/InitVal, TVAL (0x042) is read-only countdown,
// TICLR (0x044) clears the pending interrupt when bit0 is written as 1.
// Optional feature macro: TIMER_STABLE_CNT_EN adds a free-running 64-bit counter
// on stable_cnt; without it stable_cnt is tied to zero and no register exists.
module timer_unit #(
   parameter int TIMESIZE = 12,
   parameter int CSR_AW   = 14
) (
   input  logic              aclk,
   input  logic              reset,
   input  logic              csr_we,
   input  logic [CSR_AW-1:0] csr_waddr,
   input  logic [31:0]       csr_wdata,
   input  logic [CSR_AW-1:0] csr_raddr,
   output logic [31:0]       csr_rdata,
   output logic              ti_irq,
   output logic [63:0]       stable_cnt
);

   localparam int CFG_W = TIMESIZE + 2;
   localparam logic [CSR_AW-1:0] A_TCFG  = CSR_AW'(12'h041);
   localparam logic [CSR_AW-1:0] A_TVAL  = CSR_AW'(12'h042);
   localparam logic [CSR_AW-1:0] A_TICLR = CSR_AW'(12'h044);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CFG_W-1:0]    tcfg_q, tcfg_d;
   logic [TIMESIZE-1:0] tval_q, tval_d;
   logic                irq_q, irq_d;

   logic tcfg_we, ticlr_we, expire;
   logic unused_wdata;

   assign tcfg_we  = csr_we && (csr_waddr == A_TCFG);
   assign ticlr_we = csr_we && (csr_waddr == A_TICLR) && csr_wdata[0];
   assign expire   = (state_q == S_RUN) && (tval_q == '0);

   // Bits above the TCFG field are write-masked away.
   assign unused_wdata = ^csr_wdata[31:CFG_W];

   // Next-state for config, countdown, FSM and interrupt; a TCFG write overrides the
   // countdown, and an expiry setting the interrupt beats a same-cycle clear.
   always_comb begin
      tcfg_d  = tcfg_q;
      tval_d  = tval_q;
      state_d = state_q;
      irq_d   = irq_q;

      if (ticlr_we) irq_d = 1'b0;
      if (expire)   irq_d = 1'b1;

      case (state_q)
         S_RUN: begin
            if (tval_q != '0) begin
               tval_d = tval_q - 1'b1;
            end else if (tcfg_q[1]) begin
               tval_d = tcfg_q[CFG_W-1:2];
            end else begin
               state_d = S_DONE;
            end
         end
         S_IDLE, S_DONE: ;
         default: state_d = S_IDLE;
      endcase

      if (tcfg_we) begin
         tcfg_d = csr_wdata[CFG_W-1:0];
         if (csr_wdata[0]) begin
            tval_d  = csr_wdata[CFG_W-1:2];
            state_d = S_RUN;
         end else begin
            tval_d  = tval_q;
            state_d = S_IDLE;
         end
      end
   end

   // Timer state registers; reset aborts any count in progress.
   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         tcfg_q  <= '0;
         tval_q  <= '0;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tcfg_q  <= tcfg_d;
         tval_q  <= tval_d;
         irq_q   <= irq_d;
      end
   end

   assign ti_irq = irq_q;

   // Combinational CSR read mux; unmapped addresses and TICLR read as zero.
   always_comb begin
      csr_rdata = 32'd0;
      case (csr_raddr)
         A_TCFG:  csr_rdata = 32'(tcfg_q);
         A_TVAL:  csr_rdata = 32'(tval_q);
         default: csr_rdata = 32'd0;
      endcase
   end

`ifdef TIMER_STABLE_CNT_EN
   logic [63:0] stable_cnt_q, stable_cnt_d;

   // Free-running counter; wraps naturally from all-ones to zero.
   always_comb begin
      stable_cnt_d = stable_cnt_q + 64'd1;
   end

   // Stable counter register.
   always_ff @(posedge aclk or posedge reset) begin
      if (reset) stable_cnt_q <= '0;
      else       stable_cnt_q <= stable_cnt_d;
   end

   assign stable_cnt = stable_cnt_q;
`else
   assign stable_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_timer_unit.sv
// Directed bench for timer_unit: countdown, periodic reload, clear/set races,
// TCFG override, masked/ignored writes, and asynchronous reset.
module tb_timer_unit;

   localparam int TIMESIZE = 12;
   localparam int CSR_AW   = 14;
   localparam logic [CSR_AW-1:0] A_TCFG  = 14'h041;
   localparam logic [CSR_AW-1:0] A_TVAL  = 14'h042;
   localparam logic [CSR_AW-1:0] A_TICLR = 14'h044;
   localparam logic [CSR_AW-1:0] A_OTHER = 14'h050;

   logic              aclk = 1'b0;
   logic              reset;
   logic              csr_we;
   logic [CSR_AW-1:0] csr_waddr;
   logic [31:0]       csr_wdata;
   logic [CSR_AW-1:0] csr_raddr;
   logic [31:0]       csr_rdata;
   logic              ti_irq;
   logic [63:0]       stable_cnt;

   int checks = 0;
   int failures = 0;

   timer_unit #(.TIMESIZE(TIMESIZE), .CSR_AW(CSR_AW)) dut (
      .aclk       (aclk),
      .reset      (reset),
      .csr_we     (csr_we),
      .csr_waddr  (csr_waddr),
      .csr_wdata  (csr_wdata),
      .csr_raddr  (csr_raddr),
      .csr_rdata  (csr_rdata),
      .ti_irq     (ti_irq),
      .stable_cnt (stable_cnt)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; the write is applied on the next posedge, returns at the following negedge.
   task automatic wr(input logic [CSR_AW-1:0] a, input logic [31:0] d);
      csr_we = 1'b1; csr_waddr = a; csr_wdata = d;
      @(negedge aclk);
      csr_we = 1'b0; csr_waddr = '0; csr_wdata = '0;
   endtask

   task automatic rd(input logic [CSR_AW-1:0] a, output logic [31:0] d);
      csr_raddr = a;
      #1;
      d = csr_rdata;
   endtask

   task automatic chk_reg(input string tag, input logic [CSR_AW-1:0] a, input logic [31:0] exp);
      logic [31:0] d;
      rd(a, d);
      chk(tag, {32'd0, d}, {32'd0, exp});
   endtask

   task automatic step();
      @(negedge aclk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] exp_cnt;
      reset = 1'b1; csr_we = 1'b0; csr_waddr = '0; csr_wdata = '0; csr_raddr = '0;
      #1;
      chk("rst_irq", {63'd0, ti_irq}, 64'd0);
      chk_reg("rst_tcfg", A_TCFG, 32'd0);
      chk_reg("rst_tval", A_TVAL, 32'd0);
      chk("rst_cnt", stable_cnt, 64'd0);
      step(); step();
      reset = 1'b0;
      repeat (5) step();
`ifdef TIMER_STABLE_CNT_EN
      exp_cnt = 64'd5;
`else
      exp_cnt = 64'd0;
`endif
      chk("cnt_after_rel", stable_cnt, exp_cnt);
      chk_reg("idle_tval", A_TVAL, 32'd0);

      // One-shot countdown from 5.
      wr(A_TCFG, 32'h15);
      chk_reg("os_tval5", A_TVAL, 32'd5);
      for (int i = 4; i >= 0; i--) begin
         step();
         chk_reg($sformatf("os_tval%0d", i), A_TVAL, 32'(i));
         chk("os_irq_lo", {63'd0, ti_irq}, 64'd0);
      end
      step();
      chk("os_irq_hi", {63'd0, ti_irq}, 64'd1);
      chk_reg("os_tval_hold", A_TVAL, 32'd0);
      wr(A_TICLR, 32'h0);
      chk("ticlr0_noeff", {63'd0, ti_irq}, 64'd1);
      wr(A_TICLR, 32'h1);
      chk("ticlr1_clr", {63'd0, ti_irq}, 64'd0);
      repeat (5) step();
      chk("os_no_reexp", {63'd0, ti_irq}, 64'd0);
      chk_reg("os_tval_done", A_TVAL, 32'd0);

      // Periodic InitVal=3 (period 4).
      wr(A_TCFG, 32'h0F);
      chk_reg("per_t3", A_TVAL, 32'd3);
      step(); step(); step();
      chk_reg("per_t0", A_TVAL, 32'd0);
      chk("per_irq_lo", {63'd0, ti_irq}, 64'd0);
      step();
      chk("per_irq_hi", {63'd0, ti_irq}, 64'd1);
      chk_reg("per_reload", A_TVAL, 32'd3);
      wr(A_TICLR, 32'h1);
      chk("per_clr", {63'd0, ti_irq}, 64'd0);
      chk_reg("per_t2", A_TVAL, 32'd2);
      step(); step();
      chk_reg("per_t0b", A_TVAL, 32'd0);
      wr(A_TICLR, 32'h1);            // clear coincides with expiry
      chk("set_wins", {63'd0, ti_irq}, 64'd1);
      chk_reg("per_reload2", A_TVAL, 32'd3);
      wr(A_TICLR, 32'h1);
      chk("per_clr2", {63'd0, ti_irq}, 64'd0);
      step(); step();
      chk("per_irq_lo2", {63'd0, ti_irq}, 64'd0);
      step();
      chk("per_rise4", {63'd0, ti_irq}, 64'd1);
      wr(A_TICLR, 32'h1);
      chk_reg("per_t2c", A_TVAL, 32'd2);
      step(); step();
      chk_reg("per_t0c", A_TVAL, 32'd0);
      wr(A_TCFG, 32'h25);            // TCFG write coincides with expiry
      chk_reg("wr_exp_tval", A_TVAL, 32'd9);
      chk("wr_exp_irq", {63'd0, ti_irq}, 64'd1);
      chk_reg("wr_exp_tcfg", A_TCFG, 32'h25);

      // Disable mid-count, then restart.
      wr(A_TICLR, 32'h1);
      wr(A_TCFG, 32'h29);
      chk_reg("mc_t10", A_TVAL, 32'd10);
      step(); step(); step();
      chk_reg("mc_t7", A_TVAL, 32'd7);
      wr(A_TCFG, 32'h28);
      chk_reg("dis_hold", A_TVAL, 32'd7);
      repeat (3) step();
      chk_reg("dis_hold3", A_TVAL, 32'd7);
      chk("dis_irq", {63'd0, ti_irq}, 64'd0);
      wr(A_TCFG, 32'h09);
      chk_reg("re_t2", A_TVAL, 32'd2);
      step();
      chk_reg("re_t1", A_TVAL, 32'd1);
      step();
      chk_reg("re_t0", A_TVAL, 32'd0);

      // Ignored writes, unmapped reads, TCFG mask.
      wr(A_TVAL, 32'h123);
      chk_reg("tval_wr_ign", A_TVAL, 32'd0);
      chk("re_irq", {63'd0, ti_irq}, 64'd1);
      wr(A_OTHER, 32'h1);
      chk_reg("tcfg_other_wr", A_TCFG, 32'h09);
      chk_reg("rd_other", A_OTHER, 32'd0);
      chk_reg("rd_ticlr", A_TICLR, 32'd0);
      wr(A_TCFG, 32'hFFFF_FFFF);
      chk_reg("tcfg_mask", A_TCFG, 32'h3FFF);
      chk_reg("tval_full", A_TVAL, 32'hFFF);
      step();
      chk_reg("tval_fffe", A_TVAL, 32'hFFE);

      // InitVal=0 periodic expires every cycle.
      wr(A_TICLR, 32'h1);
      wr(A_TCFG, 32'h03);
      chk("iv0_irq_lo", {63'd0, ti_irq}, 64'd0);
      wr(A_TICLR, 32'h1);
      chk("iv0_exp1", {63'd0, ti_irq}, 64'd1);
      wr(A_TICLR, 32'h1);
      chk("iv0_exp2", {63'd0, ti_irq}, 64'd1);
      chk_reg("iv0_tval", A_TVAL, 32'd0);

      // Async reset mid-count with irq pending.
      wr(A_TCFG, 32'h29);
      step(); step();
      #2 reset = 1'b1;
      #1;
      chk("ar_irq", {63'd0, ti_irq}, 64'd0);
      chk_reg("ar_tcfg", A_TCFG, 32'd0);
      chk_reg("ar_tval", A_TVAL, 32'd0);
      chk("ar_cnt", stable_cnt, 64'd0);
      step();
      reset = 1'b0;
      repeat (3) step();
      chk_reg("ar_idle_tval", A_TVAL, 32'd0);
      chk("ar_idle_irq", {63'd0, ti_irq}, 64'd0);
`ifdef TIMER_STABLE_CNT_EN
      exp_cnt = 64'd3;
`else
      exp_cnt = 64'd0;
`endif
      chk("ar_cnt3", stable_cnt, exp_cnt);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
